// File: rtl/subr8s_serial_if.sv
// subr8s_serial_if: operand/result handshake bundle for the serial subtractor
interface subr8s_serial_if;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] sum;
  logic [7:0] a;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] b;
  logic       err;
  modport master (output in_valid, sum, a, out_ready, input in_ready, out_valid, b, err);
  modport slave  (input in_valid, sum, a, out_ready, output in_ready, out_valid, b, err);
endinterface

// File: rtl/subr8s_serial.sv
// subr8s_serial: bit-serial B = O - A recovery over a 10-bit sign-extended datapath
module subr8s_serial (
  input  logic             clk,
  input  logic             rst,
  subr8s_serial_if.slave   io
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] s_q, s_d, x_q, x_d, d_q, d_d;
  logic       c_q, c_d, err_q, err_d;
  logic [7:0] b_q, b_d;
  logic       bit_d, nx;
  assign nx = ~x_q[0];
  assign bit_d = s_q[0] ^ nx ^ c_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    x_d     = x_q;
    d_d     = d_q;
    c_d     = c_q;
    b_d     = b_q;
    err_d   = err_q;
    if (state_q == IDLE && io.in_valid) begin
      state_d = RUN;
      s_d     = {io.sum[8], io.sum};
      x_d     = {{2{io.a[7]}}, io.a};
      c_d     = 1'b1;
      cnt_d   = 4'd0;
    end else if (state_q == RUN && cnt_q == 4'd10) begin
      state_d = DONE;
      b_d     = d_q[7:0];
      err_d   = ~(d_q[9] == d_q[8] && d_q[8] == d_q[7]);
    end else if (state_q == RUN) begin
      s_d   = {1'b0, s_q[9:1]};
      x_d   = {1'b0, x_q[9:1]};
      d_d   = {bit_d, d_q[9:1]};
      c_d   = (s_q[0] & nx) | (s_q[0] & c_q) | (nx & c_q);
      cnt_d = cnt_q + 4'd1;
    end else if (state_q == DONE && io.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      x_q     <= '0;
      d_q     <= '0;
      c_q     <= 1'b0;
      b_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      x_q     <= x_d;
      d_q     <= d_d;
      c_q     <= c_d;
      b_q     <= b_d;
      err_q   <= err_d;
    end
  end
  assign io.in_ready  = state_q == IDLE;
  assign io.out_valid = state_q == DONE;
  assign io.b         = b_q;
  assign io.err       = err_q;
endmodule

// File: tb/tb_subr8s_serial.sv
// tb_subr8s_serial: directed and reference-checked vectors for the serial subtractor
module tb_subr8s_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  subr8s_serial_if bus ();
  subr8s_serial dut (.clk(clk), .rst(rst), .io(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [8:0] s, input logic [7:0] av, input logic ordy);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    bus.sum = s;
    bus.a = av;
    bus.out_ready = ordy;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) check("out_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
  endtask
  task automatic xfer(input string tag, input logic [8:0] s, input logic [7:0] av,
                      input logic [7:0] eb, input logic ee);
    int lat;
    start(s, av, 1'b1);
    wait_out(lat);
    check({tag, "_b"}, {24'd0, bus.b}, {24'd0, eb});
    check({tag, "_err"}, {31'd0, bus.err}, {31'd0, ee});
  endtask
  initial begin
    int lat;
    logic [7:0] hb;
    logic he;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.sum = '0;
    bus.a = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_b", {24'd0, bus.b}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    @(negedge clk) rst = 1'b0;
    start(9'h008, 8'h05, 1'b1);
    wait_out(lat);
    check("lat", lat, 32'd11);
    check("d0_b", {24'd0, bus.b}, 32'h03);
    check("d0_err", {31'd0, bus.err}, 32'd0);
    check("d0_in_ready", {31'd0, bus.in_ready}, 32'd0);
    xfer("neg_edge", 9'h100, 8'h80, 8'h80, 1'b0);
    xfer("pos_edge", 9'h0FE, 8'h7F, 8'h7F, 1'b0);
    xfer("ovf_pos", 9'h0C8, 8'h9C, 8'h2C, 1'b1);
    xfer("ovf_neg", 9'h17F, 8'h01, 8'h7E, 1'b1);
    start(9'h0C8, 8'h9C, 1'b0);
    wait_out(lat);
    hb = bus.b;
    he = bus.err;
    check("bp_b", {24'd0, hb}, 32'h2C);
    check("bp_err", {31'd0, he}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.sum = 9'h001;
      bus.a = 8'h01;
      @(posedge clk);
      #1;
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_hold_b", {24'd0, bus.b}, {24'd0, hb});
      check("bp_hold_err", {31'd0, bus.err}, {31'd0, he});
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    start(9'h008, 8'h05, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_b", {24'd0, bus.b}, 32'd0);
    check("mid_rst_err", {31'd0, bus.err}, 32'd0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      check("discard", {31'd0, bus.out_valid}, 32'd0);
    end
    xfer("after_rst", 9'h1FF, 8'hFF, 8'h00, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] ra, rb;
      int sa;
      ra = 8'($urandom);
      rb = 8'($urandom);
      sa = int'($signed(ra)) + int'($signed(rb));
      xfer("rand_ab", 9'(sa), ra, rb, 1'b0);
    end
    for (int i = 0; i < 1000; i++) begin
      logic [8:0] rs;
      logic [7:0] ra;
      int diff;
      rs = 9'($urandom);
      ra = 8'($urandom);
      diff = int'($signed(rs)) - int'($signed(ra));
      xfer("rand_raw", rs, ra, 8'(diff), (diff > 127) || (diff < -128));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
